lpc_host_io: RTL and testbench

- LPC initiator that generates LPC I/O read/write cycles from a simple request/response interface. It is used to drive TPM-style LPC traffic, and as a stimulus source for the LPC sniffer path.
- It drives lpc_frame and lpc_ad during host-owned phases, releases the bus for turnaround and SYNC, and samples peripheral SYNC and read data.
- Cycle format: START, CYCTYPE_DIR, 4 address nibbles, optional write data, TAR, SYNC, optional read data, TAR.

---
 rtl/lpc_host_io_if.sv | 26 ++
 rtl/lpc_host_io.sv | 153 +++++++++++++++
 tb/tb_lpc_host_io.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_host_io_if.sv
// LPC host I/O bundle: request/response handshake plus the LAD/LFRAME# pins.
// Request transfers on a rising edge with req_valid && req_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface lpc_host_io_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in;

    // master is the LPC initiator; slave is the requester and peripheral side
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_status, lpc_frame, lpc_ad_out, lpc_ad_oe
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status, lpc_frame, lpc_ad_out, lpc_ad_oe
    );
endinterface

// File: rtl/lpc_host_io.sv
// LPC initiator: turns single I/O read/write requests into LPC bus cycles,
// decodes peripheral SYNC (with short/long wait timeouts) and reports completion.
module lpc_host_io #(
    parameter logic [3:0] START_CODE   = 4'b0101,
    parameter int         SYNC_TIMEOUT = 8,
    parameter int         LONG_TIMEOUT = 64
) (
    input  logic          lpc_clock,
    input  logic          reset,
    lpc_host_io_if.master bus,
    output logic [3:0]    dbg_state
);
    localparam int CW = $clog2(LONG_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA,
        S_TAR_H, S_SYNC, S_RDATA, S_TAR_P, S_ABORT
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    phase, phase_nx;
    logic [CW-1:0] sync_cnt, sync_cnt_nx, sync_limit;
    logic          long_wait, long_wait_nx;
    logic          wr_q;
    logic [15:0]   addr_q;
    logic [7:0]    wdata_q, rdata_sh;
    logic [1:0]    status_q;
    logic          frame_nx, oe_nx, rsp_valid_nx;
    logic [3:0]    ad_nx;
    logic          accept, sync_done, sync_long;

    assign accept     = (state == S_IDLE) && bus.req_valid;
    assign sync_done  = (bus.lpc_ad_in == 4'h0) || (bus.lpc_ad_in == 4'hA);
    // a long-wait nibble widens the limit on the very cycle it is seen
    assign sync_long  = long_wait || (bus.lpc_ad_in == 4'b0110);
    assign sync_limit = sync_long ? CW'(LONG_TIMEOUT) : CW'(SYNC_TIMEOUT);
    assign dbg_state  = state;

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            phase          <= 2'd0;
            sync_cnt       <= '0;
            long_wait      <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= 16'h0;
            wdata_q        <= 8'h0;
            rdata_sh       <= 8'h0;
            status_q       <= 2'b00;
            bus.lpc_frame  <= 1'b1;
            bus.lpc_ad_oe  <= 1'b0;
            bus.lpc_ad_out <= 4'hF;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= 8'h0;
            bus.rsp_status <= 2'b00;
        end else begin
            state          <= state_nx;
            phase          <= phase_nx;
            sync_cnt       <= sync_cnt_nx;
            long_wait      <= long_wait_nx;
            bus.lpc_frame  <= frame_nx;
            bus.lpc_ad_oe  <= oe_nx;
            bus.lpc_ad_out <= ad_nx;
            bus.req_ready  <= (state_nx == S_IDLE);
            bus.rsp_valid  <= rsp_valid_nx;
            if (accept) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == S_SYNC && sync_done)
                status_q <= (bus.lpc_ad_in == 4'hA) ? 2'b01 : 2'b00;
            if (state == S_RDATA) begin
                if (phase == 2'd0) rdata_sh[3:0] <= bus.lpc_ad_in;
                else               rdata_sh[7:4] <= bus.lpc_ad_in;
            end
            // read data becomes visible only when the cycle completes normally
            if (rsp_valid_nx) begin
                bus.rsp_status <= (state == S_ABORT) ? 2'b10 : status_q;
                if (state == S_TAR_P && !wr_q) bus.rsp_rdata <= rdata_sh;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        sync_cnt_nx  = sync_cnt;
        long_wait_nx = long_wait;
        case (state)
            S_IDLE:    if (accept) state_nx = S_START;
            S_START:   state_nx = S_CYCTYPE;
            S_CYCTYPE: state_nx = S_ADDR;
            S_ADDR:    if (phase == 2'd3) state_nx = wr_q ? S_WDATA : S_TAR_H;
            S_WDATA:   if (phase == 2'd1) state_nx = S_TAR_H;
            S_TAR_H: begin
                if (phase == 2'd1) begin
                    state_nx     = S_SYNC;
                    sync_cnt_nx  = CW'(1);
                    long_wait_nx = 1'b0;
                end
            end
            S_SYNC: begin
                long_wait_nx = sync_long;
                if (sync_done)                    state_nx = wr_q ? S_TAR_P : S_RDATA;
                else if (sync_cnt >= sync_limit)  state_nx = S_ABORT;
                else                              sync_cnt_nx = sync_cnt + 1'b1;
            end
            S_RDATA:   if (phase == 2'd1) state_nx = S_TAR_P;
            S_TAR_P:   if (phase == 2'd1) state_nx = S_IDLE;
            S_ABORT:   if (phase == 2'd3) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        phase_nx = (state_nx != state) ? 2'd0 : phase + 2'd1;
    end

    always_comb begin
        frame_nx     = 1'b1;
        oe_nx        = 1'b0;
        ad_nx        = 4'hF;
        rsp_valid_nx = (state_nx == S_IDLE) && (state == S_TAR_P || state == S_ABORT);
        case (state_nx)
            S_START: begin
                frame_nx = 1'b0;
                oe_nx    = 1'b1;
                ad_nx    = START_CODE;
            end
            S_CYCTYPE: begin
                oe_nx = 1'b1;
                ad_nx = wr_q ? 4'b0010 : 4'b0000;
            end
            S_ADDR: begin
                oe_nx = 1'b1;
                case (phase_nx)
                    2'd0:    ad_nx = addr_q[15:12];
                    2'd1:    ad_nx = addr_q[11:8];
                    2'd2:    ad_nx = addr_q[7:4];
                    default: ad_nx = addr_q[3:0];
                endcase
            end
            S_WDATA: begin
                oe_nx = 1'b1;
                ad_nx = (phase_nx == 2'd0) ? wdata_q[3:0] : wdata_q[7:4];
            end
            S_TAR_H: oe_nx = (phase_nx == 2'd0);
            S_ABORT: begin
                frame_nx = 1'b0;
                oe_nx    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lpc_host_io.sv
// Bench for lpc_host_io: two instances (long timeout 64 and 16) see identical stimulus
// and are checked cycle by cycle against an expected bus trace built from the protocol rules.
module tb_lpc_host_io;
    localparam logic [3:0] START_CODE = 4'b0101;
    localparam int SYNC_TIMEOUT = 8;
    localparam int LONG_A = 64;
    localparam int LONG_B = 16;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic        req_valid, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [3:0]  lpc_ad_in;
    logic [3:0]  dbg0, dbg1;

    lpc_host_io_if b0();
    lpc_host_io_if b1();

    assign b0.req_valid = req_valid;
    assign b0.req_write = req_write;
    assign b0.req_addr  = req_addr;
    assign b0.req_wdata = req_wdata;
    assign b0.lpc_ad_in = lpc_ad_in;
    assign b1.req_valid = req_valid;
    assign b1.req_write = req_write;
    assign b1.req_addr  = req_addr;
    assign b1.req_wdata = req_wdata;
    assign b1.lpc_ad_in = lpc_ad_in;

    lpc_host_io #(.START_CODE(START_CODE), .SYNC_TIMEOUT(SYNC_TIMEOUT), .LONG_TIMEOUT(LONG_A)) u_dut0 (
        .lpc_clock(lpc_clock), .reset(lpc_reset), .bus(b0), .dbg_state(dbg0));
    lpc_host_io #(.START_CODE(START_CODE), .SYNC_TIMEOUT(SYNC_TIMEOUT), .LONG_TIMEOUT(LONG_B)) u_dut1 (
        .lpc_clock(lpc_clock), .reset(lpc_reset), .bus(b1), .dbg_state(dbg1));

    // clock / reset
    always #5 lpc_clock = ~lpc_clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // scoreboard: entry = {frame, oe, ad[3:0], rsp_valid, req_ready, status[1:0], rdata[7:0]}
    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    logic [3:0]  sync_q[$];
    logic [3:0]  in_q[$];
    logic [7:0]  rd_hold [2];

    function automatic logic [17:0] ent(input logic frame, input logic oe, input logic [3:0] ad,
                                        input logic rv, input logic rr, input logic [1:0] st,
                                        input logic [7:0] rd);
        return {frame, oe, ad, rv, rr, st, rd};
    endfunction

    function automatic logic [17:0] idle_ent(input int d);
        return ent(1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 2'b00, rd_hold[d]);
    endfunction

    // peripheral SYNC nibble in SYNC cycle n (1-based); an empty queue means nobody answers
    function automatic logic [3:0] sample_at(input int n);
        return (n <= sync_q.size()) ? sync_q[n-1] : 4'hF;
    endfunction

    task automatic cmp(input string tag, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, d, cyc, act, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic [17:0] e);
        logic frame, oe, rv, rr;
        logic [3:0] ad;
        logic [1:0] st;
        logic [7:0] rd;
        if (d == 0) begin
            frame = b0.lpc_frame; oe = b0.lpc_ad_oe; ad = b0.lpc_ad_out; rv = b0.rsp_valid;
            rr = b0.req_ready; st = b0.rsp_status; rd = b0.rsp_rdata;
        end else begin
            frame = b1.lpc_frame; oe = b1.lpc_ad_oe; ad = b1.lpc_ad_out; rv = b1.rsp_valid;
            rr = b1.req_ready; st = b1.rsp_status; rd = b1.rsp_rdata;
        end
        cmp("lpc_frame", d, 8'(frame), 8'(e[17]));
        cmp("lpc_ad_oe", d, 8'(oe), 8'(e[16]));
        if (e[16]) cmp("lpc_ad_out", d, 8'(ad), 8'(e[15:12]));
        cmp("rsp_valid", d, 8'(rv), 8'(e[11]));
        cmp("req_ready", d, 8'(rr), 8'(e[10]));
        if (e[11]) cmp("rsp_status", d, 8'(st), 8'(e[9:8]));
        cmp("rsp_rdata", d, rd, e[7:0]);
    endtask

    // reference model: outcome of the SYNC phase from the wait/timeout rules
    task automatic sync_outcome(input int long_lim, output int n, output logic [1:0] st);
        logic lw, done;
        logic [3:0] s;
        lw = 1'b0; done = 1'b0; n = 0; st = 2'b10;
        while (!done && n < 200) begin
            n++;
            s = sample_at(n);
            if (s == 4'b0110) lw = 1'b1;
            if (s == 4'h0)      begin st = 2'b00; done = 1'b1; end
            else if (s == 4'hA) begin st = 2'b01; done = 1'b1; end
            else if (n >= (lw ? long_lim : SYNC_TIMEOUT)) begin st = 2'b10; done = 1'b1; end
        end
    endtask

    task automatic push(input int d, input logic [17:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic build_trace(input int d, input int long_lim, input logic wr, input logic [15:0] addr,
                               input logic [7:0] wd, input logic [7:0] rd, output int n_sync,
                               output logic [1:0] st);
        logic [7:0] h, nrd;
        h = rd_hold[d];
        sync_outcome(long_lim, n_sync, st);
        push(d, ent(1'b0, 1'b1, START_CODE, 1'b0, 1'b0, 2'b00, h));
        push(d, ent(1'b1, 1'b1, wr ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 2'b00, h));
        for (int i = 3; i >= 0; i--) push(d, ent(1'b1, 1'b1, addr[i*4 +: 4], 1'b0, 1'b0, 2'b00, h));
        if (wr) begin
            push(d, ent(1'b1, 1'b1, wd[3:0], 1'b0, 1'b0, 2'b00, h));
            push(d, ent(1'b1, 1'b1, wd[7:4], 1'b0, 1'b0, 2'b00, h));
        end
        push(d, ent(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 2'b00, h));
        push(d, ent(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 2'b00, h));
        repeat (n_sync) push(d, ent(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 2'b00, h));
        if (st == 2'b10) begin
            repeat (4) push(d, ent(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 2'b00, h));
        end else begin
            repeat (wr ? 2 : 4) push(d, ent(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 2'b00, h));
        end
        nrd = (!wr && st != 2'b10) ? rd : h;
        push(d, ent(1'b1, 1'b0, 4'hF, 1'b1, 1'b1, st, nrd));
        rd_hold[d] = nrd;
    endtask

    // driver: one request, peripheral replies from sync_q then rd nibbles; called at a negedge
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd);
        int n0, n1, ncyc;
        logic [1:0] st0, st1;
        exp_q0.delete(); exp_q1.delete(); in_q.delete();
        build_trace(0, LONG_A, wr, addr, wd, rd, n0, st0);
        build_trace(1, LONG_B, wr, addr, wd, rd, n1, st1);
        repeat (wr ? 10 : 8) in_q.push_back(4'hF);
        for (int i = 1; i <= n0; i++) in_q.push_back(sample_at(i));
        if (!wr && st0 != 2'b10) begin
            in_q.push_back(rd[3:0]);
            in_q.push_back(rd[7:4]);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; lpc_ad_in = 4'hF;
        cyc = 0;
        cmp("req_ready_accept", 0, 8'(b0.req_ready), 8'h01);
        cmp("req_ready_accept", 1, 8'(b1.req_ready), 8'h01);
        @(posedge lpc_clock);
        @(negedge lpc_clock);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
        ncyc = ((exp_q0.size() > exp_q1.size()) ? exp_q0.size() : exp_q1.size()) + 1;
        for (int c = 1; c <= ncyc; c++) begin
            cyc = c;
            lpc_ad_in = (c <= in_q.size()) ? in_q[c-1] : 4'hF;
            check_dut(0, (exp_q0.size() != 0) ? exp_q0.pop_front() : idle_ent(0));
            check_dut(1, (exp_q1.size() != 0) ? exp_q1.pop_front() : idle_ent(1));
            @(negedge lpc_clock);
        end
    endtask

    initial begin
        lpc_reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 8'h0; lpc_ad_in = 4'hF;
        rd_hold[0] = 8'h00; rd_hold[1] = 8'h00;

        // reset state
        @(negedge lpc_clock);
        check_dut(0, idle_ent(0));
        check_dut(1, idle_ent(1));
        cmp("reset_ad", 0, 8'(b0.lpc_ad_out), 8'h0F);
        cmp("reset_status", 0, 8'(b0.rsp_status), 8'h00);
        @(negedge lpc_clock);
        lpc_reset = 1'b0;
        @(negedge lpc_clock);

        // write 0x0024 <- 0xA5, immediate SYNC ok
        sync_q = '{4'h0};
        run_txn(1'b1, 16'h0024, 8'hA5, 8'h00);

        // read 0x0024, three short waits, data 0xC3
        sync_q = '{4'h5, 4'h5, 4'h5, 4'h0};
        run_txn(1'b0, 16'h0024, 8'h00, 8'hC3);

        // no responder: abort, rdata kept
        sync_q.delete();
        run_txn(1'b0, 16'h1234, 8'h00, 8'h5A);

        // long wait x20: completes with 64, aborts with 16
        sync_q.delete();
        repeat (20) sync_q.push_back(4'b0110);
        sync_q.push_back(4'h0);
        run_txn(1'b0, 16'hBEEF, 8'h00, 8'h96);

        // SYNC error on a read still captures data
        sync_q = '{4'h5, 4'hA};
        run_txn(1'b0, 16'h8001, 8'h00, 8'h7E);

        // 0000 arriving on the limit cycle completes
        sync_q = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        run_txn(1'b1, 16'hFFFF, 8'h3C, 8'h00);

        // reset asserted during ADDR
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4321; req_wdata = 8'h00;
        @(posedge lpc_clock);
        @(negedge lpc_clock);
        req_valid = 1'b0;
        repeat (3) @(negedge lpc_clock);
        #2 lpc_reset = 1'b1;
        #1;
        cyc = -1;
        rd_hold[0] = 8'h00; rd_hold[1] = 8'h00;
        check_dut(0, idle_ent(0));
        check_dut(1, idle_ent(1));
        repeat (2) @(negedge lpc_clock);
        lpc_reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cyc = 100 + c;
            check_dut(0, idle_ent(0));
            check_dut(1, idle_ent(1));
            @(negedge lpc_clock);
        end
        sync_q = '{4'h0};
        run_txn(1'b0, 16'h4321, 8'h00, 8'hE1);

        // randomized requests and SYNC sequences
        for (int t = 0; t < 12; t++) begin
            int nw;
            logic [3:0] v;
            nw = $urandom_range(0, 10);
            sync_q.delete();
            for (int k = 0; k < nw; k++) begin
                do v = 4'($urandom_range(0, 15)); while (v == 4'h0 || v == 4'hA);
                sync_q.push_back(v);
            end
            sync_q.push_back(($urandom_range(0, 1) != 0) ? 4'h0 : 4'hA);
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
